// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-CPU microsequencer.
//   - Opcode values (upper nibble of IR).
//   - Control-word bit positions and the fixed fetch / halt words.
//   - Microstep names used by the decoder.
//   - cw(): builds a one-hot control word from a bit position.
package ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned CW_HLT     = 15;
  localparam int unsigned CW_MI      = 14;
  localparam int unsigned CW_RI      = 13;
  localparam int unsigned CW_RO      = 12;
  localparam int unsigned CW_IO      = 11;
  localparam int unsigned CW_II      = 10;
  localparam int unsigned CW_AI      = 9;
  localparam int unsigned CW_AO      = 8;
  localparam int unsigned CW_SUMOUT  = 7;
  localparam int unsigned CW_SUB     = 6;
  localparam int unsigned CW_BI      = 5;
  localparam int unsigned CW_OI      = 4;
  localparam int unsigned CW_CE      = 3;
  localparam int unsigned CW_CO      = 2;
  localparam int unsigned CW_J       = 1;
  localparam int unsigned CW_FLAGSIN = 0;

  localparam logic [15:0] CW_T0   = 16'h4004;  // co | mi
  localparam logic [15:0] CW_T1   = 16'h1408;  // ro | ii | ce
  localparam logic [15:0] CW_HALT = 16'h8000;  // hlt

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } step_t;

  function automatic logic [15:0] cw(input int unsigned idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/ctrl_ucode.sv
// Combinational microcode decoder.
//   step      : current microstep (0..7)
//   instr     : opcode (OPW bits; the low 4 bits are decoded)
//   cf, zf    : latched carry / zero flags, consulted only at T2
//   ctrl_word : control strobes for this step (no halt override here)
//   last      : high on the final meaningful step of the current opcode
module ctrl_ucode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [2:0]     step,
  input  logic [OPW-1:0] instr,
  input  logic           cf,
  input  logic           zf,
  output logic [15:0]    ctrl_word,
  output logic           last
);

  logic [3:0] op;
  step_t      last_step;

  assign op = 4'(instr);

  always_comb begin
    ctrl_word = '0;
    case (step_t'(step))
      T0: ctrl_word = CW_T0;
      T1: ctrl_word = CW_T1;
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_word = cw(CW_IO) | cw(CW_MI);
          OP_LDI: ctrl_word = cw(CW_IO) | cw(CW_AI);
          OP_JMP: ctrl_word = cw(CW_IO) | cw(CW_J);
          OP_JC:  ctrl_word = cf ? (cw(CW_IO) | cw(CW_J)) : '0;
          OP_JZ:  ctrl_word = zf ? (cw(CW_IO) | cw(CW_J)) : '0;
          OP_OUT: ctrl_word = cw(CW_AO) | cw(CW_OI);
          OP_HLT: ctrl_word = cw(CW_HLT);
          default: ctrl_word = '0;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA:         ctrl_word = cw(CW_RO) | cw(CW_AI);
          OP_ADD, OP_SUB: ctrl_word = cw(CW_RO) | cw(CW_BI);
          OP_STA:         ctrl_word = cw(CW_AO) | cw(CW_RI);
          default:        ctrl_word = '0;
        endcase
      end
      T4: begin
        case (op)
          OP_ADD:  ctrl_word = cw(CW_SUMOUT) | cw(CW_AI) | cw(CW_FLAGSIN);
          OP_SUB:  ctrl_word = cw(CW_SUMOUT) | cw(CW_SUB) | cw(CW_AI) | cw(CW_FLAGSIN);
          default: ctrl_word = '0;
        endcase
      end
      default: ctrl_word = '0;
    endcase
  end

  // Last step depends only on the opcode; a not-taken JC/JZ still ends at T2.
  always_comb begin
    last_step = T1;
    case (op)
      OP_LDA, OP_STA:                         last_step = T3;
      OP_ADD, OP_SUB:                         last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
      OP_HLT:                                 last_step = T2;
      default:                                last_step = T1;
    endcase
  end

  assign last = (step == last_step);

endmodule

// File: rtl/ctrl_seq.sv
// Microsequencer for the 8-bit accumulator CPU.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : step enable (ignored once halted)
//   instr      : opcode from IR upper nibble (must be stable from end of T1)
//   cf, zf     : latched ALU flags for JC / JZ
//   ctrl_word  : 16-bit control strobes, combinational from step/instr/flags/halted
//   step       : current microstep
//   halted     : sticky halt, cleared only by rst_n
// Build option: define CTRL_SEQ_STEP_SKIP_EN to return to T0 right after the
// last meaningful step of each opcode instead of always running STEPS steps.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned STEPS = 5,
  parameter int unsigned OPW   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] instr,
  input  logic           cf,
  input  logic           zf,
  output logic [15:0]    ctrl_word,
  output logic [2:0]     step,
  output logic           halted
);

  localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] ucode_word;
  logic        last;
  logic        wrap;

  ctrl_ucode #(
    .OPW(OPW)
  ) u_ucode (
    .step      (step_q),
    .instr     (instr),
    .cf        (cf),
    .zf        (zf),
    .ctrl_word (ucode_word),
    .last      (last)
  );

`ifdef CTRL_SEQ_STEP_SKIP_EN
  assign wrap = (step_q == STEP_LAST) || last;
`else
  logic unused_last;
  assign unused_last = last;
  assign wrap        = (step_q == STEP_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // HLT freezes the counter at T2 on the edge that would end T2.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (step_q == 3'd2 && instr == OPW'(OP_HLT)) begin
        halted_d = 1'b1;
      end else if (wrap) begin
        step_d = '0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  assign ctrl_word = halted_q ? CW_HALT : ucode_word;
  assign step      = step_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  instr;
  logic        cf;
  logic        zf;
  logic [15:0] ctrl_word;
  logic [2:0]  step;
  logic        halted;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  instr;
    logic        cf;
    logic        zf;
    logic        run;
    logic [2:0]  exp_step;
    logic [15:0] exp_cw;
  } vec_t;

  vec_t tbl[$];

`ifdef CTRL_SEQ_STEP_SKIP_EN
  localparam int LEN_LDI = 3, LEN_LDA = 4, LEN_NOP = 2, LEN_JMP = 3,
                 LEN_STA = 4, LEN_OUT = 3, LEN_ADD = 5, LEN_SUB = 5;
`else
  localparam int LEN_LDI = 5, LEN_LDA = 5, LEN_NOP = 5, LEN_JMP = 5,
                 LEN_STA = 5, LEN_OUT = 5, LEN_ADD = 5, LEN_SUB = 5;
`endif

  ctrl_seq #(
    .STEPS(5),
    .OPW  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr     (instr),
    .cf        (cf),
    .zf        (zf),
    .ctrl_word (ctrl_word),
    .step      (step),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [2:0] s,
                           input logic [15:0] w, input logic h);
    chk({name, ".step"}, 32'(step), 32'(s));
    chk({name, ".cw"}, 32'(ctrl_word), 32'(w));
    chk({name, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_zero(input string name);
    int n = 0;
    while (step != 3'd0 && n < 12) begin
      tick();
      n++;
    end
    chk({name, ".to_zero"}, 32'(step), 32'd0);
  endtask

  // Starting at T0, run one instruction and count edges until step returns to 0.
  task automatic run_len(input string name, input logic [3:0] op, input int exp_len);
    int n = 0;
    instr = op;
    run   = 1'b1;
    #1;
    chk({name, ".t0"}, 32'(ctrl_word), 32'h4004);
    do begin
      tick();
      n++;
    end while (step != 3'd0 && n < 12);
    chk({name, ".len"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    instr = 4'h0;
    cf    = 1'b0;
    zf    = 1'b0;

    // Reset state
    tick();
    tick();
    chk_state("reset", 3'd0, 16'h4004, 1'b0);
    rst_n = 1'b1;
    #1;

    // ADD then SUB, with a 3-cycle run=0 hold at SUB T4; flags toggled off-T2.
    tbl.push_back('{4'h1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h4004});
    tbl.push_back('{4'h1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1408});
    tbl.push_back('{4'h1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h4800});
    tbl.push_back('{4'h1, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1020});
    tbl.push_back('{4'h1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0281});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b1, 3'd0, 16'h4004});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b0, 3'd1, 16'h1408});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1408});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b1, 3'd2, 16'h4800});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1020});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b0, 3'd4, 16'h02C1});
    tbl.push_back('{4'h2, 1'b1, 1'b0, 1'b0, 3'd4, 16'h02C1});
    tbl.push_back('{4'h2, 1'b0, 1'b1, 1'b0, 3'd4, 16'h02C1});
    tbl.push_back('{4'h2, 1'b0, 1'b0, 1'b1, 3'd4, 16'h02C1});
    tbl.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h4004});

    foreach (tbl[i]) begin
      instr = tbl[i].instr;
      cf    = tbl[i].cf;
      zf    = tbl[i].zf;
      run   = tbl[i].run;
      #1;
      chk_state($sformatf("vec%0d", i), tbl[i].exp_step, tbl[i].exp_cw, 1'b0);
      tick();
    end
    cf = 1'b0;
    zf = 1'b0;

    // JC at T2: cf decides; zf ignored.
    instr = 4'h6;
    run   = 1'b1;
    tick();
    tick();
    chk("jc.step", 32'(step), 32'd2);
    cf = 1'b1; #1; chk("jc.cf1", 32'(ctrl_word), 32'h0802);
    cf = 1'b0; #1; chk("jc.cf0", 32'(ctrl_word), 32'h0000);
    zf = 1'b1; #1; chk("jc.zf_only", 32'(ctrl_word), 32'h0000);
    zf = 1'b0;
    tick();
`ifdef CTRL_SEQ_STEP_SKIP_EN
    chk("jc.skip_step", 32'(step), 32'd0);
`else
    chk("jc.t3_step", 32'(step), 32'd3);
    cf = 1'b1; #1; chk("jc.t3_cf1", 32'(ctrl_word), 32'h0000);
    cf = 1'b0; #1; chk("jc.t3_cf0", 32'(ctrl_word), 32'h0000);
`endif
    to_zero("jc");

    // JZ at T2: zf decides; cf ignored.
    instr = 4'h7;
    tick();
    tick();
    zf = 1'b1; #1; chk("jz.zf1", 32'(ctrl_word), 32'h0802);
    zf = 1'b0; #1; chk("jz.zf0", 32'(ctrl_word), 32'h0000);
    cf = 1'b1; #1; chk("jz.cf_only", 32'(ctrl_word), 32'h0000);
    cf = 1'b0;
    to_zero("jz");

    // Instruction lengths (build dependent)
    run_len("ldi", 4'h4, LEN_LDI);
    run_len("lda", 4'h0, LEN_LDA);
    run_len("nop", 4'h9, LEN_NOP);
    run_len("jmp", 4'h5, LEN_JMP);
    run_len("sta", 4'h3, LEN_STA);
    run_len("out", 4'hE, LEN_OUT);
    run_len("add", 4'h1, LEN_ADD);
    run_len("sub", 4'h2, LEN_SUB);

    // Asynchronous reset in the middle of ADD T3
    instr = 4'h1;
    run   = 1'b1;
    tick();
    tick();
    tick();
    chk_state("add_t3", 3'd3, 16'h1020, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 3'd0, 16'h4004, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_state("after_rst", 3'd0, 16'h4004, 1'b0);

    // HLT: run=0 at T2 does not halt; run=1 does; then sticky.
    instr = 4'hF;
    tick();
    tick();
    chk_state("hlt_t2", 3'd2, 16'h8000, 1'b0);
    run = 1'b0;
    tick();
    chk_state("hlt_run0", 3'd2, 16'h8000, 1'b0);
    run = 1'b1;
    tick();
    chk_state("hlt_set", 3'd2, 16'h8000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run   = i[0];
      cf    = ~cf;
      instr = (i == 5) ? 4'h1 : 4'hF;
      tick();
      chk_state($sformatf("halted%0d", i), 3'd2, 16'h8000, 1'b1);
    end
    instr = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("hlt_rst", 3'd0, 16'h4004, 1'b0);
    tick();
    rst_n = 1'b1;
    run   = 1'b1;
    tick();
    chk_state("post_hlt_run", 3'd1, 16'h1408, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
